riscv_alu_shared_issue: RTL and testbench
=========================================

RISCV_ALU_SHARED_ISSUE -- requirements
Module: riscv_alu_shared_issue

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of requesting cores (2..8).
REQ-002 SHALL have parameter ALU_OP_WIDTH, default 7, operator field width.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have core-side ports, per core i, packed by index:
- core_req_i  in  NUM_CORES  operation request.
- core_gnt_o  out  NUM_CORES  request accepted.
- core_operator_i  in  NUM_CORES*ALU_OP_WIDTH  ALU operator.
- core_op_a_i / core_op_b_i / core_op_c_i  in  NUM_CORES*32 each  operands.
- core_vec_mode_i  in  NUM_CORES*3  vector mode.
- core_rvalid_o  out  NUM_CORES  result held.
- core_rready_i  in  NUM_CORES  result consumed.
- core_result_o  out  NUM_CORES*32  result.
- core_cmp_o  out  NUM_CORES  comparison result.
REQ-005 SHALL have shared-unit ports:
- alu_req_o  out  1  issue request.
- alu_gnt_i  in  1  issue accepted.
- alu_operator_o  out  ALU_OP_WIDTH  operator.
- alu_op_a_o / alu_op_b_o / alu_op_c_o  out  32 each  operands.
- alu_vec_mode_o  out  3  vector mode.
- alu_rvalid_i  in  1  result valid; no backpressure.
- alu_result_i  in  32  result.
- alu_cmp_i  in  1  comparison result.

Function
REQ-006 SHALL keep per-core state IDLE/WAIT/RESP; only IDLE cores with core_req_i=1 are eligible.
REQ-007 SHALL select among eligible cores round-robin, starting at pointer rr_ptr.
REQ-008 SHALL drive alu_req_o=1 and the selected core's operator/operands/vec_mode when any core is eligible or a lock is held; when alu_req_o=0, all alu_* outputs SHALL be 0.
REQ-009 SHALL lock the selected core while alu_req_o=1 and alu_gnt_i=0; the selection and alu_* outputs SHALL stay unchanged until the grant arrives.
REQ-010 SHALL assert core_gnt_o[sel] combinationally in the cycle where alu_req_o=1 and alu_gnt_i=1; at most one core_gnt_o bit SHALL be high per cycle.
REQ-011 On issue, SHALL set rr_ptr=(sel+1) mod NUM_CORES, move core sel IDLE->WAIT, and push sel into the in-order ID FIFO.
REQ-012 The ID FIFO depth SHALL be NUM_CORES; since each core has at most one op in flight, it SHALL never overflow.
REQ-013 On alu_rvalid_i=1 with the FIFO non-empty, SHALL:
- pop head ID k;
- register alu_result_i and alu_cmp_i into core k's response register;
- move core k WAIT->RESP.
REQ-014 core_rvalid_o[k] SHALL be 1 exactly while core k is in RESP, first asserted the cycle after alu_rvalid_i; issue-to-core latency is the unit latency + 1 cycle.
REQ-015 core_result_o/core_cmp_o for a core SHALL hold their value while in RESP and SHALL be 0 otherwise.
REQ-016 On core_rvalid_o[k]=1 and core_rready_i[k]=1, SHALL move core k RESP->IDLE; the core becomes eligible the following cycle, never in the same cycle.
REQ-017 Push and pop in the same cycle SHALL both take effect; FIFO occupancy stays unchanged.
REQ-018 An alu_rvalid_i with an empty FIFO SHALL be dropped with no state change; simulation SHALL flag it with an assertion.
REQ-019 Results SHALL be routed strictly in issue order, independent of rr_ptr.

Reset
REQ-020 While rst_n=0 at a rising edge:
- all cores to IDLE; FIFO empty; rr_ptr=0; lock cleared; response registers 0.
- all outputs 0 the next cycle.
REQ-021 Results arriving after reset for ops issued before reset SHALL be dropped per REQ-018.

Verification
REQ-022 Single issue: core0 requests ADD a=5, b=7 with alu_gnt_i=1; unit returns 12 after 2 cycles -> core_gnt_o=01 in the request cycle, core_rvalid_o[0]=1 with result 12 one cycle after alu_rvalid_i.
REQ-023 Fairness: both cores request continuously, gnt always 1, responses immediate and rready=1 -> issue order 0,1,0,1; each core re-granted no earlier than 1 cycle after its own rready handshake.
REQ-024 Lock: core1 selected with alu_gnt_i=0 for 3 cycles while core0 raises req -> alu_op_a_o stays core1's value; core1 is granted first; rr_ptr=0 afterwards.
REQ-025 Ordering/hold: issue core0 then core1; core0 rready=0 for 4 cycles -> core1 gets its result while core0's result stays stable; core0 is not re-granted until rready.
REQ-026 Reset mid-flight: reset while both cores are in WAIT, then alu_rvalid_i=1 -> no core_rvalid_o, all outputs 0, FIFO empty.

Source files
------------

// File: rtl/riscv_alu_shared_issue.sv
// Purpose : N cores share one ALU. Requests are picked round-robin and issued in order.
//           Results return through an in-order ID FIFO to the core that issued the op.
// Latency : issue grant is combinational (same cycle). Result reaches core_rvalid_o the cycle after alu_rvalid_i.
// Backpres: an ungranted request locks the selection and operands. A core holds its result until core_rready_i.
//           alu_rvalid_i cannot be back-pressured.
//
// Ports:
//   clk, rst_n                 single clock, synchronous active-low reset
//   core_req_i / core_gnt_o    per-core request / combinational accept
//   core_operator_i, core_op_{a,b,c}_i, core_vec_mode_i   per-core op fields, packed by core index
//   core_rvalid_o / core_rready_i, core_result_o, core_cmp_o   per-core response handshake and data
//   alu_req_o / alu_gnt_i, alu_operator_o, alu_op_{a,b,c}_o, alu_vec_mode_o   issue side of the shared ALU
//   alu_rvalid_i, alu_result_i, alu_cmp_i   result side of the shared ALU, no backpressure

// Purpose : generic synchronous FIFO with valid/ready on both sides; DEPTH need not be a power of two.
// Latency : a pushed entry is visible on out_dat the cycle after the push.
// Backpres: in_rdy drops when full; out_vld drops when empty; a push and a pop in the same cycle both take effect.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign in_rdy  = (count != CW'(DEPTH));
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module riscv_alu_shared_issue #(
    parameter int NUM_CORES    = 2,
    parameter int ALU_OP_WIDTH = 7
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic [NUM_CORES-1:0]              core_req_i,
    output logic [NUM_CORES-1:0]              core_gnt_o,
    input  logic [NUM_CORES*ALU_OP_WIDTH-1:0] core_operator_i,
    input  logic [NUM_CORES*32-1:0]           core_op_a_i,
    input  logic [NUM_CORES*32-1:0]           core_op_b_i,
    input  logic [NUM_CORES*32-1:0]           core_op_c_i,
    input  logic [NUM_CORES*3-1:0]            core_vec_mode_i,
    output logic [NUM_CORES-1:0]              core_rvalid_o,
    input  logic [NUM_CORES-1:0]              core_rready_i,
    output logic [NUM_CORES*32-1:0]           core_result_o,
    output logic [NUM_CORES-1:0]              core_cmp_o,

    output logic                              alu_req_o,
    input  logic                              alu_gnt_i,
    output logic [ALU_OP_WIDTH-1:0]           alu_operator_o,
    output logic [31:0]                       alu_op_a_o,
    output logic [31:0]                       alu_op_b_o,
    output logic [31:0]                       alu_op_c_o,
    output logic [2:0]                        alu_vec_mode_o,
    input  logic                              alu_rvalid_i,
    input  logic [31:0]                       alu_result_i,
    input  logic                              alu_cmp_i
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } core_st_e;

    core_st_e                core_st       [NUM_CORES];
    logic [31:0]             resp_result   [NUM_CORES];
    logic [NUM_CORES-1:0]    resp_cmp;

    logic [ALU_OP_WIDTH-1:0] operator_arr  [NUM_CORES];
    logic [31:0]             op_a_arr      [NUM_CORES];
    logic [31:0]             op_b_arr      [NUM_CORES];
    logic [31:0]             op_c_arr      [NUM_CORES];
    logic [2:0]              vec_mode_arr  [NUM_CORES];

    logic [NUM_CORES-1:0]    eligible;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        rr_sel;
    logic                    rr_hit;
    logic [IDX_W-1:0]        sel;
    logic [IDX_W-1:0]        sel_next_ptr;

    // Lock: the selected core and its op fields are captured while the ALU
    // stalls the grant, so the request presented to the ALU cannot change.
    logic                    lock_vld;
    logic [IDX_W-1:0]        lock_sel;
    logic [ALU_OP_WIDTH-1:0] lock_operator;
    logic [31:0]             lock_op_a;
    logic [31:0]             lock_op_b;
    logic [31:0]             lock_op_c;
    logic [2:0]              lock_vec_mode;

    logic                    issue;
    logic                    pop;
    logic                    fifo_in_rdy;
    logic                    fifo_out_vld;
    logic [IDX_W-1:0]        fifo_head;

    // Unpack the per-core buses once so everything below indexes by core.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            operator_arr[i] = core_operator_i[i*ALU_OP_WIDTH +: ALU_OP_WIDTH];
            op_a_arr[i]     = core_op_a_i[i*32 +: 32];
            op_b_arr[i]     = core_op_b_i[i*32 +: 32];
            op_c_arr[i]     = core_op_c_i[i*32 +: 32];
            vec_mode_arr[i] = core_vec_mode_i[i*3 +: 3];
        end
    end

    // Only idle cores may request. rst_n gates eligibility so nothing is
    // presented to the ALU while reset is held.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i] = rst_n && core_req_i[i] && (core_st[i] == ST_IDLE);
        end
    end

    // Round-robin: scan from rr_ptr upward with wrap-around, first eligible wins.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        idx    = 0;
        cand   = '0;
        rr_sel = rr_ptr;
        rr_hit = 1'b0;
        for (int off = 0; off < NUM_CORES; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            cand = IDX_W'(idx);
            if (!rr_hit && eligible[cand]) begin
                rr_hit = 1'b1;
                rr_sel = cand;
            end
        end
    end

    assign sel          = lock_vld ? lock_sel : rr_sel;
    assign sel_next_ptr = (sel == IDX_W'(NUM_CORES - 1)) ? '0 : sel + IDX_W'(1);
    assign alu_req_o    = rst_n && (lock_vld || rr_hit);
    // The FIFO holds NUM_CORES entries and each core has at most one op in
    // flight, so fifo_in_rdy is always high here. It is kept as a guard only.
    assign issue        = alu_req_o && alu_gnt_i && fifo_in_rdy;
    assign pop          = alu_rvalid_i && fifo_out_vld;

    always_comb begin
        alu_operator_o = '0;
        alu_op_a_o     = '0;
        alu_op_b_o     = '0;
        alu_op_c_o     = '0;
        alu_vec_mode_o = '0;
        if (alu_req_o) begin
            if (lock_vld) begin
                alu_operator_o = lock_operator;
                alu_op_a_o     = lock_op_a;
                alu_op_b_o     = lock_op_b;
                alu_op_c_o     = lock_op_c;
                alu_vec_mode_o = lock_vec_mode;
            end else begin
                alu_operator_o = operator_arr[sel];
                alu_op_a_o     = op_a_arr[sel];
                alu_op_b_o     = op_b_arr[sel];
                alu_op_c_o     = op_c_arr[sel];
                alu_vec_mode_o = vec_mode_arr[sel];
            end
        end
    end

    always_comb begin
        core_gnt_o = '0;
        if (issue) begin
            core_gnt_o[sel] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            core_rvalid_o[i]         = (core_st[i] == ST_RESP);
            core_result_o[i*32 +: 32] = core_rvalid_o[i] ? resp_result[i] : 32'd0;
            core_cmp_o[i]            = core_rvalid_o[i] && resp_cmp[i];
        end
    end

    // In-order ID FIFO: records which core owns each op in flight at the ALU.
    fifo_sync #(
        .WIDTH (IDX_W),
        .DEPTH (NUM_CORES)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (issue),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (sel),
        .out_vld (fifo_out_vld),
        .out_rdy (alu_rvalid_i),
        .out_dat (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            lock_vld      <= 1'b0;
            lock_sel      <= '0;
            lock_operator <= '0;
            lock_op_a     <= '0;
            lock_op_b     <= '0;
            lock_op_c     <= '0;
            lock_vec_mode <= '0;
            resp_cmp      <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                core_st[i]     <= ST_IDLE;
                resp_result[i] <= '0;
            end
        end else begin
            if (issue) begin
                rr_ptr   <= sel_next_ptr;
                lock_vld <= 1'b0;
            end else if (alu_req_o && !lock_vld) begin
                lock_vld      <= 1'b1;
                lock_sel      <= sel;
                lock_operator <= operator_arr[sel];
                lock_op_a     <= op_a_arr[sel];
                lock_op_b     <= op_b_arr[sel];
                lock_op_c     <= op_c_arr[sel];
                lock_vec_mode <= vec_mode_arr[sel];
            end

            // Issue targets an IDLE core, a pop targets a WAIT core and a
            // release targets a RESP core. One core never sees two events at once.
            for (int i = 0; i < NUM_CORES; i++) begin
                case (core_st[i])
                    ST_IDLE: begin
                        if (issue && (sel == IDX_W'(i))) begin
                            core_st[i] <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (pop && (fifo_head == IDX_W'(i))) begin
                            core_st[i]     <= ST_RESP;
                            resp_result[i] <= alu_result_i;
                            resp_cmp[i]    <= alu_cmp_i;
                        end
                    end
                    ST_RESP: begin
                        if (core_rready_i[i]) begin
                            core_st[i] <= ST_IDLE;
                        end
                    end
                    default: core_st[i] <= ST_IDLE;
                endcase
            end
        end
    end

    // A result with nothing outstanding is dropped. This includes results
    // for ops that were issued before a reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(alu_rvalid_i && !fifo_out_vld))
                else $warning("alu_rvalid_i with no op outstanding, result dropped");
        end
    end
endmodule

// File: tb/tb_riscv_alu_shared_issue.sv
module tb_riscv_alu_shared_issue;
    localparam int N  = 2;
    localparam int OW = 7;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    core_req_i;
    logic [N-1:0]    core_gnt_o;
    logic [N*OW-1:0] core_operator_i;
    logic [N*32-1:0] core_op_a_i;
    logic [N*32-1:0] core_op_b_i;
    logic [N*32-1:0] core_op_c_i;
    logic [N*3-1:0]  core_vec_mode_i;
    logic [N-1:0]    core_rvalid_o;
    logic [N-1:0]    core_rready_i;
    logic [N*32-1:0] core_result_o;
    logic [N-1:0]    core_cmp_o;
    logic            alu_req_o;
    logic            alu_gnt_i;
    logic [OW-1:0]   alu_operator_o;
    logic [31:0]     alu_op_a_o;
    logic [31:0]     alu_op_b_o;
    logic [31:0]     alu_op_c_o;
    logic [2:0]      alu_vec_mode_o;
    logic            alu_rvalid_i;
    logic [31:0]     alu_result_i;
    logic            alu_cmp_i;

    int n_chk  = 0;
    int n_pass = 0;

    riscv_alu_shared_issue #(
        .NUM_CORES    (N),
        .ALU_OP_WIDTH (OW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_req_i      (core_req_i),
        .core_gnt_o      (core_gnt_o),
        .core_operator_i (core_operator_i),
        .core_op_a_i     (core_op_a_i),
        .core_op_b_i     (core_op_b_i),
        .core_op_c_i     (core_op_c_i),
        .core_vec_mode_i (core_vec_mode_i),
        .core_rvalid_o   (core_rvalid_o),
        .core_rready_i   (core_rready_i),
        .core_result_o   (core_result_o),
        .core_cmp_o      (core_cmp_o),
        .alu_req_o       (alu_req_o),
        .alu_gnt_i       (alu_gnt_i),
        .alu_operator_o  (alu_operator_o),
        .alu_op_a_o      (alu_op_a_o),
        .alu_op_b_o      (alu_op_b_o),
        .alu_op_c_o      (alu_op_c_o),
        .alu_vec_mode_o  (alu_vec_mode_o),
        .alu_rvalid_i    (alu_rvalid_i),
        .alu_result_i    (alu_result_i),
        .alu_cmp_i       (alu_cmp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Outputs are sampled 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_req_i      = '0;
        core_operator_i = '0;
        core_op_a_i     = '0;
        core_op_b_i     = '0;
        core_op_c_i     = '0;
        core_vec_mode_i = '0;
        core_rready_i   = '0;
        alu_gnt_i       = 1'b0;
        alu_rvalid_i    = 1'b0;
        alu_result_i    = '0;
        alu_cmp_i       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    logic [1:0]  fair_gnt [6];
    logic [1:0]  fair_rv  [6];
    logic        fair_in  [6];
    logic [31:0] fair_opa [6];

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // ---- reset: outputs quiet even with requests pending ----
        core_req_i = 2'b11;
        cyc();
        cyc();
        #1;
        chk("rst_alu_req", alu_req_o, 0);
        chk("rst_core_gnt", core_gnt_o, 0);
        rst_n      = 1'b1;
        core_req_i = 2'b00;
        #1;
        chk("rst_rvalid", core_rvalid_o, 0);
        chk("rst_result", core_result_o[63:32] | core_result_o[31:0], 0);
        chk("rst_alu_op_a", alu_op_a_o, 0);
        cyc();

        // ---- single issue: ADD 5+7, ALU answers two cycles later ----
        core_operator_i[6:0] = 7'h18;
        core_op_a_i[31:0]    = 32'd5;
        core_op_b_i[31:0]    = 32'd7;
        core_req_i           = 2'b01;
        alu_gnt_i            = 1'b1;
        #1;
        chk("t1_gnt", core_gnt_o, 2'b01);
        chk("t1_alu_req", alu_req_o, 1);
        chk("t1_operator", alu_operator_o, 7'h18);
        chk("t1_op_a", alu_op_a_o, 5);
        chk("t1_op_b", alu_op_b_o, 7);
        cyc();
        core_req_i = 2'b00;
        #1;
        chk("t1_req_drop", alu_req_o, 0);
        chk("t1_op_a_zero", alu_op_a_o, 0);
        cyc();
        alu_rvalid_i = 1'b1;
        alu_result_i = 32'd12;
        alu_cmp_i    = 1'b1;
        #1;
        chk("t1_rvalid_early", core_rvalid_o, 0);
        cyc();
        alu_rvalid_i = 1'b0;
        alu_result_i = '0;
        alu_cmp_i    = 1'b0;
        #1;
        chk("t1_rvalid", core_rvalid_o, 2'b01);
        chk("t1_result", core_result_o[31:0], 12);
        chk("t1_cmp", core_cmp_o, 2'b01);
        core_rready_i = 2'b01;
        cyc();
        core_rready_i = 2'b00;
        #1;
        chk("t1_released", core_rvalid_o, 0);
        chk("t1_result_zero", core_result_o[31:0], 0);
        chk("t1_cmp_zero", core_cmp_o, 0);

        // ---- fairness: both cores request continuously ----
        do_reset();
        fair_gnt = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
        fair_rv  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        fair_in  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        fair_opa = '{32'h11, 32'h22, 32'h0, 32'h11, 32'h22, 32'h0};
        core_op_a_i   = {32'h22, 32'h11};
        core_req_i    = 2'b11;
        core_rready_i = 2'b11;
        alu_gnt_i     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            alu_rvalid_i = fair_in[c];
            alu_result_i = 32'hA000 + c;
            #1;
            chk($sformatf("fair_gnt_c%0d", c), core_gnt_o, fair_gnt[c]);
            chk($sformatf("fair_rvalid_c%0d", c), core_rvalid_o, fair_rv[c]);
            chk($sformatf("fair_op_a_c%0d", c), alu_op_a_o, fair_opa[c]);
            if (c == 2) chk("fair_result0", core_result_o[31:0], 32'hA001);
            if (c == 3) chk("fair_result1", core_result_o[63:32], 32'hA002);
            cyc();
        end

        // ---- lock: core1 held through 3 stalled cycles while core0 requests ----
        do_reset();
        core_op_a_i = {32'h22, 32'h11};
        core_req_i  = 2'b10;
        alu_gnt_i   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("lock_req_c%0d", c), alu_req_o, 1);
            chk($sformatf("lock_op_a_c%0d", c), alu_op_a_o, 32'h22);
            chk($sformatf("lock_gnt_c%0d", c), core_gnt_o, 0);
            cyc();
            core_req_i = 2'b11;
        end
        alu_gnt_i = 1'b1;
        #1;
        chk("lock_grant", core_gnt_o, 2'b10);
        chk("lock_grant_op_a", alu_op_a_o, 32'h22);
        cyc();
        #1;
        chk("lock_next_gnt", core_gnt_o, 2'b01);
        chk("lock_next_op_a", alu_op_a_o, 32'h11);

        // ---- ordering / hold: core0 stalls its rready for 4 cycles ----
        do_reset();
        core_op_a_i = {32'h22, 32'h11};
        alu_gnt_i   = 1'b1;
        core_req_i  = 2'b01;
        #1;
        chk("ord_gnt0", core_gnt_o, 2'b01);
        cyc();
        core_req_i = 2'b11;
        #1;
        chk("ord_gnt1", core_gnt_o, 2'b10);
        cyc();
        core_req_i   = 2'b01;
        alu_rvalid_i = 1'b1;
        alu_result_i = 32'h55;
        #1;
        chk("ord_c2_gnt", core_gnt_o, 0);
        chk("ord_c2_rvalid", core_rvalid_o, 0);
        cyc();
        alu_result_i = 32'h66;
        #1;
        chk("ord_c3_rvalid", core_rvalid_o, 2'b01);
        chk("ord_c3_res0", core_result_o[31:0], 32'h55);
        chk("ord_c3_gnt", core_gnt_o, 0);
        cyc();
        alu_rvalid_i  = 1'b0;
        alu_result_i  = '0;
        core_rready_i = 2'b10;
        #1;
        chk("ord_c4_rvalid", core_rvalid_o, 2'b11);
        chk("ord_c4_res0", core_result_o[31:0], 32'h55);
        chk("ord_c4_res1", core_result_o[63:32], 32'h66);
        cyc();
        core_rready_i = 2'b00;
        for (int c = 5; c < 7; c++) begin
            #1;
            chk($sformatf("ord_c%0d_rvalid", c), core_rvalid_o, 2'b01);
            chk($sformatf("ord_c%0d_res0", c), core_result_o[31:0], 32'h55);
            chk($sformatf("ord_c%0d_res1", c), core_result_o[63:32], 0);
            chk($sformatf("ord_c%0d_gnt", c), core_gnt_o, 0);
            cyc();
        end
        core_rready_i = 2'b01;
        #1;
        chk("ord_c7_gnt", core_gnt_o, 0);
        chk("ord_c7_rvalid", core_rvalid_o, 2'b01);
        cyc();
        core_rready_i = 2'b00;
        #1;
        chk("ord_c8_gnt", core_gnt_o, 2'b01);
        chk("ord_c8_rvalid", core_rvalid_o, 0);

        // ---- reset with both cores waiting, then a stale result ----
        do_reset();
        core_op_a_i = {32'h22, 32'h11};
        alu_gnt_i   = 1'b1;
        core_req_i  = 2'b01;
        #1;
        chk("rmf_gnt0", core_gnt_o, 2'b01);
        cyc();
        core_req_i = 2'b10;
        #1;
        chk("rmf_gnt1", core_gnt_o, 2'b10);
        cyc();
        core_req_i = 2'b00;
        rst_n      = 1'b0;
        #1;
        chk("rmf_in_reset_req", alu_req_o, 0);
        cyc();
        rst_n        = 1'b1;
        alu_rvalid_i = 1'b1;
        alu_result_i = 32'h77;
        alu_cmp_i    = 1'b1;
        #1;
        chk("rmf_post_rvalid", core_rvalid_o, 0);
        cyc();
        alu_rvalid_i = 1'b0;
        alu_result_i = '0;
        alu_cmp_i    = 1'b0;
        #1;
        chk("rmf_dropped_rvalid", core_rvalid_o, 0);
        chk("rmf_res0", core_result_o[31:0], 0);
        chk("rmf_res1", core_result_o[63:32], 0);
        chk("rmf_cmp", core_cmp_o, 0);
        chk("rmf_alu_req", alu_req_o, 0);
        // A fresh op from core1 must come back to core1. Any ID left in the FIFO from before the reset would misroute it.
        core_req_i = 2'b10;
        #1;
        chk("rmf_new_gnt", core_gnt_o, 2'b10);
        cyc();
        core_req_i   = 2'b00;
        alu_rvalid_i = 1'b1;
        alu_result_i = 32'h88;
        alu_cmp_i    = 1'b1;
        cyc();
        alu_rvalid_i = 1'b0;
        alu_result_i = '0;
        alu_cmp_i    = 1'b0;
        #1;
        chk("rmf_new_rvalid", core_rvalid_o, 2'b10);
        chk("rmf_new_res1", core_result_o[63:32], 32'h88);
        chk("rmf_new_cmp", core_cmp_o, 2'b10);
        chk("rmf_new_res0", core_result_o[31:0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
